// File: rtl/mem_line_seq_pkg.sv
// Shared types for the cache line sequencer.
// State enum, cache-side select encoding and beat helper.
package mem_line_seq_pkg;

  typedef enum logic [1:0] {
    IDLE,
    START,
    XFER,
    GAP
  } state_t;

  typedef enum logic {
    SEL_D = 1'b0,
    SEL_I = 1'b1
  } sel_t;

  localparam int LINE_LENGTH_DEF = 4;
  localparam int BEATS = 2 * LINE_LENGTH_DEF;

  function automatic int beats_of(input int line_length);
    return 2 * line_length;
  endfunction

endpackage

// File: rtl/mem_line_seq_arb.sv
// rr_arb2: two-way round-robin arbiter with lock.
// Ports: clk, reset, req_d/req_i, lock, en, upd/upd_sel (last-served update), gnt/gnt_sel.
module rr_arb2
  import mem_line_seq_pkg::*;
(
  input  logic clk,
  input  logic reset,
  input  logic req_d,
  input  logic req_i,
  input  logic lock,
  input  logic en,
  input  logic upd,
  input  sel_t upd_sel,
  output logic gnt,
  output sel_t gnt_sel
);

  sel_t last_q;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      last_q <= SEL_D;
    end else if (upd) begin
      last_q <= upd_sel;
    end
  end

  // Lock forces the dcache side; a locked-out icache simply waits.
  always_comb begin
    gnt     = 1'b0;
    gnt_sel = SEL_D;
    if (en) begin
      if (lock) begin
        gnt     = req_d;
        gnt_sel = SEL_D;
      end else if (req_d && req_i) begin
        gnt     = 1'b1;
        gnt_sel = (last_q == SEL_D) ? SEL_I : SEL_D;
      end else if (req_d) begin
        gnt     = 1'b1;
        gnt_sel = SEL_D;
      end else if (req_i) begin
        gnt     = 1'b1;
        gnt_sel = SEL_I;
      end
    end
  end

endmodule

// File: rtl/mem_line_seq.sv
// Sequences whole-line nibble transfers between dcache/icache and memory.
// Ports: d_* dcache side, i_* icache side, mem_* external nibble port.
module mem_line_seq
  import mem_line_seq_pkg::*;
#(
  parameter int LINE_LENGTH = 4,
  parameter int PA = 22,
  parameter int LB = $clog2(LINE_LENGTH)
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            d_req,
  input  logic            d_hit,
  input  logic            d_push,
  input  logic            d_pull,
  input  logic [PA-LB-1:0] d_tag,
  input  logic [3:0]      d_dwrite,
  output logic            d_rstrobe,
  output logic            d_wstrobe,
  output logic [3:0]      d_dread,
  input  logic            i_req,
  input  logic [PA-LB-1:0] i_tag,
  output logic            i_wstrobe,
  output logic [3:0]      i_dread,
  output logic            mem_start,
  output logic            mem_write,
  output logic [PA-LB-1:0] mem_addr,
  output logic [3:0]      mem_wdata,
  input  logic [3:0]      mem_rdata,
  input  logic            mem_beat
);

  localparam int NB = beats_of(LINE_LENGTH);
  localparam int CW = $clog2(NB);
  localparam int AW = PA - LB;

  state_t         state_q, state_d;
  logic [CW-1:0]  cnt_q, cnt_d;
  logic           lock_q, lock_d;
  sel_t           sel_q, sel_d;
  logic           dir_q, dir_d;
  logic [AW-1:0]  addr_q, addr_d;

  logic dreq;
  logic gnt;
  sel_t gnt_sel;
  logic upd;
  logic xfer;

  assign dreq = d_req && !d_hit && (d_push || d_pull);
  assign xfer = (state_q == XFER);

  rr_arb2 u_arb (
    .clk     (clk),
    .reset   (reset),
    .req_d   (dreq),
    .req_i   (i_req),
    .lock    (lock_q),
    .en      (state_q == IDLE),
    .upd     (upd),
    .upd_sel (sel_q),
    .gnt     (gnt),
    .gnt_sel (gnt_sel)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      lock_q  <= 1'b0;
      sel_q   <= SEL_D;
      dir_q   <= 1'b0;
      addr_q  <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      lock_q  <= lock_d;
      sel_q   <= sel_d;
      dir_q   <= dir_d;
      addr_q  <= addr_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    lock_d    = lock_q;
    sel_d     = sel_q;
    dir_d     = dir_q;
    addr_d    = addr_q;
    upd       = 1'b0;
    mem_start = 1'b0;
    mem_write = 1'b0;
    d_rstrobe = 1'b0;
    d_wstrobe = 1'b0;
    i_wstrobe = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (gnt) begin
          sel_d   = gnt_sel;
          dir_d   = (gnt_sel == SEL_D) && d_push;
          addr_d  = (gnt_sel == SEL_D) ? d_tag : i_tag;
          lock_d  = 1'b0;
          state_d = START;
        end
      end
      START: begin
        mem_start = 1'b1;
        mem_write = dir_q;
        state_d   = XFER;
      end
      XFER: begin
        mem_write = dir_q;
        if (mem_beat) begin
          d_rstrobe = (sel_q == SEL_D) && dir_q;
          d_wstrobe = (sel_q == SEL_D) && !dir_q;
          i_wstrobe = (sel_q == SEL_I);
          if (cnt_q == CW'(NB - 1)) begin
            cnt_d   = '0;
            upd     = 1'b1;
            state_d = GAP;
          end else begin
            cnt_d = cnt_q + CW'(1);
          end
        end
      end
      GAP: begin
        // A writeback must be followed by its own fill.
        lock_d  = (sel_q == SEL_D) && dir_q;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  assign mem_addr  = (state_q == START || xfer) ? addr_q : '0;
  assign mem_wdata = (xfer && dir_q) ? d_dwrite : '0;
  assign d_dread   = (xfer && sel_q == SEL_D && !dir_q)
                     ? mem_rdata : '0;
  assign i_dread   = (xfer && sel_q == SEL_I) ? mem_rdata : '0;

endmodule

// File: tb/tb_mem_line_seq.sv
// Self-checking bench for mem_line_seq.
// Vector table for arbitration plus hand sequences and a scoreboard.
module tb_mem_line_seq;
  import mem_line_seq_pkg::*;

  localparam int PA = 22;
  localparam int LB = 2;
  localparam int AW = PA - LB;

  logic          clk = 1'b0;
  logic          reset;
  logic          d_req, d_hit, d_push, d_pull;
  logic [AW-1:0] d_tag;
  logic [3:0]    d_dwrite;
  logic          d_rstrobe, d_wstrobe;
  logic [3:0]    d_dread;
  logic          i_req;
  logic [AW-1:0] i_tag;
  logic          i_wstrobe;
  logic [3:0]    i_dread;
  logic          mem_start, mem_write;
  logic [AW-1:0] mem_addr;
  logic [3:0]    mem_wdata, mem_rdata;
  logic          mem_beat;

  always #5 clk = ~clk;

  mem_line_seq #(.LINE_LENGTH(4), .PA(PA)) dut (
    .clk       (clk),
    .reset     (reset),
    .d_req     (d_req),
    .d_hit     (d_hit),
    .d_push    (d_push),
    .d_pull    (d_pull),
    .d_tag     (d_tag),
    .d_dwrite  (d_dwrite),
    .d_rstrobe (d_rstrobe),
    .d_wstrobe (d_wstrobe),
    .d_dread   (d_dread),
    .i_req     (i_req),
    .i_tag     (i_tag),
    .i_wstrobe (i_wstrobe),
    .i_dread   (i_dread),
    .mem_start (mem_start),
    .mem_write (mem_write),
    .mem_addr  (mem_addr),
    .mem_wdata (mem_wdata),
    .mem_rdata (mem_rdata),
    .mem_beat  (mem_beat)
  );

  typedef struct {
    bit            sel;
    bit            wr;
    logic [AW-1:0] addr;
  } gnt_t;

  typedef struct {
    bit dr, dh, dp, dl, ir;
    bit gnt, esel, ewr;
  } vec_t;

  int   n_pass = 0;
  int   n_total = 0;
  gnt_t gq[$];
  logic [3:0] dq[$];
  logic [3:0] iq[$];
  logic [3:0] wq[$];
  bit   saw_start, active;
  int   strobes, starts;
  gnt_t cur;

  function automatic void chk(string nm, logic [31:0] act,
                              logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h want %0h", nm, act, exp);
  endfunction

  task automatic monitor();
    int ns;
    ns = int'(d_rstrobe) + int'(d_wstrobe) + int'(i_wstrobe);
    strobes += ns;
    if (mem_start) begin
      starts++;
      saw_start = 1;
      chk("start_expected", 32'(gq.size() != 0), 1);
      if (gq.size() != 0) begin
        cur = gq.pop_front();
        active = 1;
        chk("grant_write", 32'(mem_write), 32'(cur.wr));
        chk("grant_addr", 32'(mem_addr), 32'(cur.addr));
      end
    end
    if (ns != 0) begin
      chk("one_strobe", ns, 1);
      chk("xfer_active", 32'(active), 1);
      chk("addr_held", 32'(mem_addr), 32'(cur.addr));
      chk("write_held", 32'(mem_write), 32'(cur.wr));
    end
    if (d_wstrobe) begin
      chk("d_fill_avail", 32'(dq.size() != 0), 1);
      if (dq.size() != 0) chk("d_fill_data", 32'(d_dread), 32'(dq.pop_front()));
    end
    if (i_wstrobe) begin
      chk("i_fill_avail", 32'(iq.size() != 0), 1);
      if (iq.size() != 0) chk("i_fill_data", 32'(i_dread), 32'(iq.pop_front()));
    end
    if (d_rstrobe) begin
      chk("wb_avail", 32'(wq.size() != 0), 1);
      if (wq.size() != 0) chk("wb_data", 32'(mem_wdata), 32'(wq.pop_front()));
    end
  endtask

  task automatic step();
    @(negedge clk);
    monitor();
    @(posedge clk);
    #1;
  endtask

  task automatic clr();
    d_req = 0; d_hit = 0; d_push = 0; d_pull = 0; i_req = 0;
  endtask

  task automatic check_zero(string p);
    chk({p, "_addr"}, 32'(mem_addr), 0);
    chk({p, "_ctl"}, 32'({mem_start, mem_write, d_rstrobe,
                          d_wstrobe, i_wstrobe}), 0);
    chk({p, "_data"}, 32'({mem_wdata, d_dread, i_dread}), 0);
  endtask

  task automatic expect_idle(input int n);
    int s0;
    s0 = starts;
    for (int i = 0; i < n; i++) step();
    chk("no_grant", starts - s0, 0);
  endtask

  // mode: 0 keep requests, 1 drop all, 2 push->pull with new
  // d_tag, 3 drop dcache only
  task automatic do_xfer(input bit esel, input bit ewr,
                         input logic [AW-1:0] eaddr, input int mode,
                         input bit toggle, input bit stray,
                         input logic [AW-1:0] new_tag);
    gnt_t g;
    g.sel = esel; g.wr = ewr; g.addr = eaddr;
    gq.push_back(g);
    saw_start = 0;
    strobes = 0;
    for (int i = 0; i < 6; i++) begin
      step();
      if (saw_start) break;
      if (stray) mem_beat = 1;
    end
    mem_beat = 0;
    chk("start_seen", 32'(saw_start), 1);
    if (!saw_start) begin
      gq.delete();
      return;
    end
    case (mode)
      1: clr();
      2: begin d_push = 0; d_pull = 1; d_tag = new_tag; end
      3: d_req = 0;
      default: ;
    endcase
    for (int b = 0; b < BEATS; b++) begin
      mem_beat = 1;
      mem_rdata = 4'($urandom_range(15));
      d_dwrite = 4'(7 - b);
      if (ewr) wq.push_back(d_dwrite);
      else if (esel) iq.push_back(mem_rdata);
      else dq.push_back(mem_rdata);
      step();
      if (toggle) begin
        mem_beat = 0;
        step();
      end
    end
    mem_beat = 1;
    step();
    step();
    mem_beat = 0;
    active = 0;
    chk("beat_strobes", strobes, BEATS);
    chk("queues_drained", dq.size() + iq.size() + wq.size(), 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1);
  end

  initial begin
    vec_t tbl[10];
    tbl[0] = '{1, 1, 0, 1, 0, 0, 0, 0};
    tbl[1] = '{1, 0, 0, 1, 0, 1, 0, 0};
    tbl[2] = '{0, 0, 0, 0, 1, 1, 1, 0};
    tbl[3] = '{1, 0, 0, 1, 1, 1, 0, 0};
    tbl[4] = '{1, 0, 0, 1, 1, 1, 1, 0};
    tbl[5] = '{1, 0, 1, 0, 1, 1, 0, 1};
    tbl[6] = '{0, 0, 0, 0, 1, 0, 0, 0};
    tbl[7] = '{1, 0, 0, 1, 1, 1, 0, 0};
    tbl[8] = '{1, 0, 0, 1, 1, 1, 1, 0};
    tbl[9] = '{1, 0, 0, 0, 0, 0, 0, 0};

    reset = 1;
    clr();
    d_tag = '0; i_tag = '0; d_dwrite = 4'h5;
    mem_rdata = 4'hA; mem_beat = 0;
    saw_start = 0; active = 0; strobes = 0; starts = 0;
    step();
    step();
    @(negedge clk);
    check_zero("reset");
    @(posedge clk);
    #1;
    reset = 0;
    step();

    for (int r = 0; r < 10; r++) begin
      d_req = tbl[r].dr; d_hit = tbl[r].dh;
      d_push = tbl[r].dp; d_pull = tbl[r].dl;
      i_req = tbl[r].ir;
      d_tag = (r == 1) ? AW'(20'h01234) : AW'(20'h01234 + r * 20'h111);
      i_tag = AW'(20'hABC00 + r);
      if (tbl[r].gnt)
        do_xfer(tbl[r].esel, tbl[r].ewr,
                tbl[r].esel ? i_tag : d_tag, 1, 0, 0, '0);
      else begin
        expect_idle(4);
        clr();
      end
    end

    // writeback then fill, icache locked out meanwhile
    clr();
    d_req = 1; d_push = 1; d_tag = AW'(20'h02000);
    i_req = 1; i_tag = AW'(20'h03000);
    do_xfer(SEL_D, 1, AW'(20'h02000), 2, 0, 0, AW'(20'h02100));
    do_xfer(SEL_D, 0, AW'(20'h02100), 3, 0, 0, '0);
    do_xfer(SEL_I, 0, AW'(20'h03000), 1, 0, 0, '0);

    // continuous requests alternate
    d_req = 1; d_pull = 1; d_tag = AW'(20'h04000);
    i_req = 1; i_tag = AW'(20'h05000);
    do_xfer(SEL_D, 0, AW'(20'h04000), 0, 0, 0, '0);
    do_xfer(SEL_I, 0, AW'(20'h05000), 0, 0, 0, '0);
    do_xfer(SEL_D, 0, AW'(20'h04000), 0, 0, 0, '0);
    do_xfer(SEL_I, 0, AW'(20'h05000), 1, 0, 0, '0);

    // reset after 3 beats of an icache fill
    clr();
    step();
    i_req = 1; i_tag = AW'(20'h06000);
    begin
      gnt_t g;
      g.sel = SEL_I; g.wr = 0; g.addr = AW'(20'h06000);
      gq.push_back(g);
    end
    saw_start = 0;
    strobes = 0;
    for (int i = 0; i < 6; i++) begin
      step();
      if (saw_start) break;
    end
    chk("rst_start_seen", 32'(saw_start), 1);
    i_req = 0;
    for (int b = 0; b < 3; b++) begin
      mem_beat = 1;
      mem_rdata = 4'($urandom_range(1, 15));
      iq.push_back(mem_rdata);
      step();
    end
    reset = 1;
    @(negedge clk);
    check_zero("rst_mid");
    chk("pre_reset_beats", strobes, 3);
    @(posedge clk);
    #1;
    step();
    reset = 0;
    mem_beat = 0;
    active = 0;
    gq.delete();
    iq.delete();
    step();
    d_req = 1; d_pull = 1; d_tag = AW'(20'h07000);
    i_req = 1; i_tag = AW'(20'h06100);
    do_xfer(SEL_I, 0, AW'(20'h06100), 1, 0, 0, '0);

    // toggling beats plus a stray beat during START
    d_req = 1; d_pull = 1; d_tag = AW'(20'h08000);
    do_xfer(SEL_D, 0, AW'(20'h08000), 1, 1, 1, '0);

    // request dropped mid-writeback
    d_req = 1; d_push = 1; d_tag = AW'(20'h09000);
    do_xfer(SEL_D, 1, AW'(20'h09000), 1, 0, 0, '0);
    expect_idle(4);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
